// File: rtl/fifo_4bit_bus_if.sv
// fifo_4bit_bus_if: handshake bundle between a producer/consumer and the
// fifo_4bit_bus buffer.
//   wr_en, wr_data      : write request and word (producer -> FIFO)
//   rd_en               : read request (consumer -> FIFO)
//   clr_err             : synchronous clear of the sticky error flags
//   rd_data, rd_valid   : registered read word and its one-cycle valid pulse
//   full, empty, count  : occupancy status
//   overflow, underflow : sticky error flags
// The master modport is the user side; the slave modport is the FIFO side.
interface fifo_4bit_bus_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
) ();
  localparam int CW = $clog2(DEPTH) + 1;

  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic             clr_err;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             full;
  logic             empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output wr_en, wr_data, rd_en, clr_err,
    input  rd_data, rd_valid, full, empty, count, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en, clr_err,
    output rd_data, rd_valid, full, empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_4bit_bus.sv
// fifo_4bit_bus: synchronous FIFO for narrow data words with a registered,
// one-cycle-latency read, occupancy count and sticky error flags.
// Ports:
//   clk   : single clock, all state changes on the rising edge
//   reset : asynchronous active-high reset, clears all state immediately
//   bus   : fifo_4bit_bus_if slave modport (requests in, data/status out)
// DEPTH must be a power of two between 2 and 64 so that the pointers wrap
// modulo DEPTH simply by overflowing their natural width.
module fifo_4bit_bus #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
) (
  input  logic           clk,
  input  logic           reset,
  fifo_4bit_bus_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] rd_data_q;
  logic             rd_valid_q;
  logic             overflow_q;
  logic             underflow_q;

  logic full_c;
  logic empty_c;
  logic rd_acc;
  logic wr_acc;
  logic ovf_set;
  logic udf_set;

  // Status comes straight from the registered count, so an asynchronous
  // reset shows empty immediately rather than at the next edge.
  assign empty_c = (count_q == '0);
  assign full_c  = (count_q == COUNT_FULL);

  // A read frees a slot in the same cycle, so a write to a full FIFO is
  // still accepted when paired with a read. No fall-through when empty.
  assign rd_acc = bus.rd_en && !empty_c;
  assign wr_acc = bus.wr_en && (!full_c || rd_acc);

  assign ovf_set = bus.wr_en && full_c && !bus.rd_en;
  assign udf_set = bus.rd_en && empty_c;

  // Storage is deliberately not reset; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wp] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (wr_acc) wp <= wp + 1'b1;
      if (rd_acc) rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      unique case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // rd_data holds its last value whenever no read is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_acc;
      if (rd_acc) rd_data_q <= mem[rp];
    end
  end

  // A new error in the same cycle as clr_err takes priority over the clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (ovf_set)          overflow_q <= 1'b1;
      else if (bus.clr_err) overflow_q <= 1'b0;

      if (udf_set)          underflow_q <= 1'b1;
      else if (bus.clr_err) underflow_q <= 1'b0;
    end
  end

  assign bus.rd_data   = rd_data_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.full      = full_c;
  assign bus.empty     = empty_c;
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_fifo_4bit_bus.sv
// tb_fifo_4bit_bus: self-checking bench for fifo_4bit_bus. A behavioural
// queue model decides acceptance; expected read words are pushed to a
// scoreboard when the read is driven and popped when rd_valid appears.
module tb_fifo_4bit_bus;
  localparam int WIDTH = 4;
  localparam int DEPTH = 8;

  logic clk;
  logic reset;

  fifo_4bit_bus_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  fifo_4bit_bus #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] mdl[$];
  logic [WIDTH-1:0] exp_q[$];
  logic             ovf_m;
  logic             udf_m;
  logic [WIDTH-1:0] last_rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_status();
    check("count", 32'(bus.count), 32'(mdl.size()));
    check("full", 32'(bus.full), 32'(mdl.size() == DEPTH));
    check("empty", 32'(bus.empty), 32'(mdl.size() == 0));
    check("overflow", 32'(bus.overflow), 32'(ovf_m));
    check("underflow", 32'(bus.underflow), 32'(udf_m));
  endtask

  task automatic model_reset();
    mdl.delete();
    exp_q.delete();
    ovf_m   = 1'b0;
    udf_m   = 1'b0;
    last_rd = '0;
  endtask

  // One clock cycle of stimulus, with the model updated from pre-edge state.
  task automatic step(input logic wr, input logic [WIDTH-1:0] d,
                      input logic rd, input logic clr);
    bit racc, wacc, ovf_set, udf_set;
    int pre;
    pre         = mdl.size();
    bus.wr_en   = wr;
    bus.wr_data = d;
    bus.rd_en   = rd;
    bus.clr_err = clr;
    racc    = rd && (pre > 0);
    wacc    = wr && ((pre < DEPTH) || racc);
    ovf_set = wr && (pre == DEPTH) && !rd;
    udf_set = rd && (pre == 0);
    if (racc) exp_q.push_back(mdl.pop_front());
    if (wacc) mdl.push_back(d);
    if (ovf_set)  ovf_m = 1'b1;
    else if (clr) ovf_m = 1'b0;
    if (udf_set)  udf_m = 1'b1;
    else if (clr) udf_m = 1'b0;
    @(posedge clk);
    #1;
    check("rd_valid", 32'(bus.rd_valid), 32'(racc));
    if (racc) begin
      if (exp_q.size() == 0) begin
        check("scoreboard_empty", 32'(1), 32'(0));
      end else begin
        last_rd = exp_q.pop_front();
        check("rd_data", 32'(bus.rd_data), 32'(last_rd));
      end
    end else begin
      check("rd_data_hold", 32'(bus.rd_data), 32'(last_rd));
    end
    check_status();
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.clr_err = 1'b0;
  endtask

  task automatic fill_1_to_8();
    for (int i = 1; i <= DEPTH; i++) step(1'b1, WIDTH'(i), 1'b0, 1'b0);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.rd_en   = 1'b0;
    bus.clr_err = 1'b0;
    model_reset();
    reset = 1'b1;
    #12;
    check("reset_rd_valid", 32'(bus.rd_valid), 32'(0));
    check("reset_rd_data", 32'(bus.rd_data), 32'(0));
    check_status();
    @(negedge clk);
    reset = 1'b0;

    // Fill and drain in order.
    fill_1_to_8();
    drain(DEPTH);

    // Overflow: rejected write must not enter storage.
    fill_1_to_8();
    step(1'b1, 4'hF, 1'b0, 1'b0);
    drain(DEPTH);
    step(1'b0, '0, 1'b0, 1'b1);

    // Empty with both requests: write accepted, read rejected.
    step(1'b1, 4'hA, 1'b1, 1'b0);
    drain(1);
    // Clear and new underflow in the same cycle: flag stays set.
    step(1'b0, '0, 1'b1, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);

    // Full with both requests, then drain across the pointer wrap.
    fill_1_to_8();
    step(1'b1, 4'h9, 1'b1, 1'b0);
    drain(DEPTH);

    // Reset mid-stream, asserted between edges.
    step(1'b1, 4'h3, 1'b0, 1'b0);
    step(1'b1, 4'h4, 1'b0, 1'b0);
    step(1'b1, 4'h5, 1'b1, 1'b0);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("midrst_rd_valid", 32'(bus.rd_valid), 32'(0));
    check("midrst_rd_data", 32'(bus.rd_data), 32'(0));
    check_status();
    @(negedge clk);
    reset = 1'b0;
    step(1'b1, 4'h6, 1'b0, 1'b0);
    drain(1);

    // Streaming at occupancy 3 with simultaneous read/write.
    for (int i = 0; i < 3; i++) step(1'b1, WIDTH'(i), 1'b0, 1'b0);
    for (int i = 3; i < 23; i++) step(1'b1, WIDTH'(i), 1'b1, 1'b0);
    drain(3);

    check("scoreboard_left", 32'(exp_q.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
